key_event_controller: RTL and testbench

//  Sequencer between NUM_KEYS debounce instances and the consumer logic.

---
 rtl/key_event_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_key_event_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_controller.sv
// key_event_controller
//   Converts NUM_KEYS debounced key levels into PRESS / RELEASE / LONG /
//   REPEAT events. Each key has a small FSM driven by its edges and a shared
//   hold-tick prescaler. A one-deep pending slot per key buffers raised
//   events, and a round-robin arbiter moves them onto one valid/ready port.
//
// Ports
//   clock        in   rising-edge clock for all logic
//   reset        in   synchronous, active-high
//   signal       in   [NUM_KEYS]  debounced levels, 1 = pressed
//   event_valid  out  event payload valid
//   event_ready  in   consumer accepts when valid & ready at the edge
//   event_key    out  [KW]  key index of the event
//   event_type   out  [2]   0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   overrun      out  [NUM_KEYS]  sticky: key overwrote an unconsumed event
module key_event_controller #(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned LONG_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10,
    localparam int unsigned KW          = $clog2(NUM_KEYS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] signal,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [KW-1:0]       event_key,
    output logic [1:0]          event_type,
    output logic [NUM_KEYS-1:0] overrun
);

    localparam int unsigned MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int unsigned CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int unsigned PW   = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DOWN,
        ST_HELD
    } state_t;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_RELEASE = 2'd1,
        EV_LONG    = 2'd2,
        EV_REPEAT  = 2'd3
    } ev_t;

    // Edge detection and prescaler
    logic [NUM_KEYS-1:0] prev_q;
    logic [PW-1:0]       presc_q, presc_d;
    logic [NUM_KEYS-1:0] rise, fall;
    logic                tick;

    // Per-key FSM
    state_t              state_q [NUM_KEYS];
    state_t              state_d [NUM_KEYS];
    logic [CW-1:0]       cnt_q   [NUM_KEYS];
    logic [CW-1:0]       cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] raise;
    ev_t                 rtype   [NUM_KEYS];

    // Pending slots and overrun flags
    logic [NUM_KEYS-1:0] pend_v_q, pend_v_d;
    ev_t                 pend_t_q [NUM_KEYS];
    ev_t                 pend_t_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] ovr_q, ovr_d;

    // Arbiter and output register
    logic                load, found;
    logic [KW-1:0]       grant;
    logic [NUM_KEYS-1:0] drain;
    logic                out_v_q, out_v_d;
    logic [KW-1:0]       out_key_q, out_key_d;
    ev_t                 out_t_q, out_t_d;
    logic [KW-1:0]       last_q, last_d;

    assign rise = signal & ~prev_q;
    assign fall = ~signal & prev_q;
    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Per-key FSM: fall outranks a coincident tick in DOWN and HELD.
    always_comb begin
        raise = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            rtype[k]   = EV_PRESS;
            case (state_q[k])
                ST_IDLE: begin
                    if (rise[k]) begin
                        state_d[k] = ST_DOWN;
                        cnt_d[k]   = '0;
                        raise[k]   = 1'b1;
                        rtype[k]   = EV_PRESS;
                    end
                end
                ST_DOWN: begin
                    if (fall[k]) begin
                        state_d[k] = ST_IDLE;
                        raise[k]   = 1'b1;
                        rtype[k]   = EV_RELEASE;
                    end else if (tick) begin
                        if (cnt_q[k] == CW'(LONG_TICKS - 1)) begin
                            state_d[k] = ST_HELD;
                            cnt_d[k]   = '0;
                            raise[k]   = 1'b1;
                            rtype[k]   = EV_LONG;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CW'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (fall[k]) begin
                        state_d[k] = ST_IDLE;
                        raise[k]   = 1'b1;
                        rtype[k]   = EV_RELEASE;
                    end else if (tick) begin
                        if (cnt_q[k] == CW'(REPEAT_TICKS - 1)) begin
                            cnt_d[k] = '0;
                            raise[k] = 1'b1;
                            rtype[k] = EV_REPEAT;
                        end else begin
                            cnt_d[k] = cnt_q[k] + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // Round-robin search starting one past the last granted key.
    always_comb begin
        int unsigned idx;
        load  = !out_v_q || event_ready;
        found = 1'b0;
        grant = '0;
        drain = '0;
        for (int unsigned i = 1; i <= NUM_KEYS; i++) begin
            idx = (32'(last_q) + i) % NUM_KEYS;
            if (!found && pend_v_q[idx]) begin
                found = 1'b1;
                grant = KW'(idx);
            end
        end
        if (load && found) begin
            drain[grant] = 1'b1;
        end
    end

    // A slot drained this cycle frees room for a new event without overrun.
    always_comb begin
        ovr_d = ovr_q;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            pend_v_d[k] = pend_v_q[k];
            pend_t_d[k] = pend_t_q[k];
            if (raise[k]) begin
                if (pend_v_q[k] && !drain[k]) begin
                    ovr_d[k] = 1'b1;
                end
                pend_v_d[k] = 1'b1;
                pend_t_d[k] = rtype[k];
            end else if (drain[k]) begin
                pend_v_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        out_v_d   = out_v_q;
        out_key_d = out_key_q;
        out_t_d   = out_t_q;
        last_d    = last_q;
        if (load) begin
            if (found) begin
                out_v_d   = 1'b1;
                out_key_d = grant;
                out_t_d   = pend_t_q[grant];
                last_d    = grant;
            end else begin
                out_v_d = 1'b0;
            end
        end
    end

    // prev keeps sampling during reset so a key held across reset gives no PRESS.
    always_ff @(posedge clock) begin
        prev_q <= signal;
        if (reset) begin
            presc_q   <= '0;
            pend_v_q  <= '0;
            ovr_q     <= '0;
            out_v_q   <= 1'b0;
            out_key_q <= '0;
            out_t_q   <= EV_PRESS;
            last_q    <= KW'(NUM_KEYS - 1);
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                state_q[k]  <= ST_IDLE;
                cnt_q[k]    <= '0;
                pend_t_q[k] <= EV_PRESS;
            end
        end else begin
            presc_q   <= presc_d;
            pend_v_q  <= pend_v_d;
            ovr_q     <= ovr_d;
            out_v_q   <= out_v_d;
            out_key_q <= out_key_d;
            out_t_q   <= out_t_d;
            last_q    <= last_d;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                state_q[k]  <= state_d[k];
                cnt_q[k]    <= cnt_d[k];
                pend_t_q[k] <= pend_t_d[k];
            end
        end
    end

    assign event_valid = out_v_q;
    assign event_key   = out_key_q;
    assign event_type  = out_t_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_key_event_controller.sv
// Directed bench for key_event_controller with NUM_KEYS=4, TICK_DIV=4,
// LONG_TICKS=3, REPEAT_TICKS=2. Accepted handshakes are logged with their
// cycle number; each scenario task checks the log and outputs directly.
module tb_key_event_controller;

    localparam int unsigned NK = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] signal = '0;
    logic          event_valid;
    logic          event_ready = 1'b0;
    logic [1:0]    event_key;
    logic [1:0]    event_type;
    logic [NK-1:0] overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    int log_key[$];
    int log_type[$];
    int log_cyc[$];

    key_event_controller #(
        .NUM_KEYS    (4),
        .TICK_DIV    (4),
        .LONG_TICKS  (3),
        .REPEAT_TICKS(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .signal     (signal),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_key  (event_key),
        .event_type (event_type),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Inputs change 1 time unit after posedge, so a handshake seen here
    // completes at the following posedge.
    always @(negedge clock) begin
        if (!reset && event_valid && event_ready) begin
            log_key.push_back(int'(event_key));
            log_type.push_back(int'(event_type));
            log_cyc.push_back(cyc);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        log_key.delete();
        log_type.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        signal      = '0;
        event_ready = 1'b0;
        do_reset();
        @(negedge clock);
        tests_run++;
        if ({event_valid, event_key, event_type, overrun} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b k=%0d t=%0d ovr=%b, want all zero",
                     event_valid, event_key, event_type, overrun);
        end
    endtask

    task automatic test_short_press();
        event_ready = 1'b1;
        do_reset();
        signal[0] = 1'b1;
        cycles(6);
        signal[0] = 1'b0;
        cycles(20);
        tests_run++;
        if (log_key.size() !== 2) begin
            tests_failed++;
            $display("FAIL short_count: got %0d events, want 2", log_key.size());
        end
        if (log_key.size() >= 2) begin
            tests_run++;
            if (log_key[0] !== 0 || log_type[0] !== 0 || log_key[1] !== 0 || log_type[1] !== 1) begin
                tests_failed++;
                $display("FAIL short_seq: got (%0d,%0d)(%0d,%0d), want (0,0)(0,1)",
                         log_key[0], log_type[0], log_key[1], log_type[1]);
            end
            tests_run++;
            if (log_cyc[1] - log_cyc[0] !== 6) begin
                tests_failed++;
                $display("FAIL short_spacing: got %0d cycles, want 6", log_cyc[1] - log_cyc[0]);
            end
        end
        tests_run++;
        if (overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL short_overrun: got %b, want 0000", overrun);
        end
    endtask

    task automatic test_long_repeat();
        int exp_type[6] = '{0, 2, 3, 3, 3, 1};
        int d;
        event_ready = 1'b1;
        do_reset();
        signal[1] = 1'b1;
        cycles(40);
        signal[1] = 1'b0;
        cycles(30);
        tests_run++;
        if (log_key.size() !== 6) begin
            tests_failed++;
            $display("FAIL long_count: got %0d events, want 6", log_key.size());
        end
        if (log_key.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (log_key[i] !== 1 || log_type[i] !== exp_type[i]) begin
                    tests_failed++;
                    $display("FAIL long_event%0d: got (%0d,%0d), want (1,%0d)",
                             i, log_key[i], log_type[i], exp_type[i]);
                end
            end
            d = log_cyc[1] - log_cyc[0];
            tests_run++;
            if (d < 9 || d > 12) begin
                tests_failed++;
                $display("FAIL long_latency: got %0d cycles, want 9..12", d);
            end
            for (int i = 2; i < 5; i++) begin
                tests_run++;
                if (log_cyc[i] - log_cyc[i-1] !== 8) begin
                    tests_failed++;
                    $display("FAIL repeat_gap%0d: got %0d, want 8", i, log_cyc[i] - log_cyc[i-1]);
                end
            end
            tests_run++;
            if (log_cyc[5] - log_cyc[0] !== 40) begin
                tests_failed++;
                $display("FAIL release_time: got %0d, want 40", log_cyc[5] - log_cyc[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_key[3] = '{0, 2, 3};
        event_ready = 1'b1;
        do_reset();
        signal = 4'b1101;
        cycles(5);
        signal = 4'b0000;
        cycles(8);
        tests_run++;
        if (log_key.size() !== 6) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d events, want 6", log_key.size());
        end
        if (log_key.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (log_key[i] !== exp_key[i % 3] || log_type[i] !== (i / 3)) begin
                    tests_failed++;
                    $display("FAIL b2b_event%0d: got (%0d,%0d), want (%0d,%0d)",
                             i, log_key[i], log_type[i], exp_key[i % 3], i / 3);
                end
            end
            tests_run++;
            if (log_cyc[1] - log_cyc[0] !== 1 || log_cyc[2] - log_cyc[1] !== 1) begin
                tests_failed++;
                $display("FAIL b2b_consecutive: got gaps %0d,%0d, want 1,1",
                         log_cyc[1] - log_cyc[0], log_cyc[2] - log_cyc[1]);
            end
        end
    endtask

    task automatic test_overrun();
        event_ready = 1'b0;
        do_reset();
        signal[2] = 1'b1;
        cycles(3);
        signal[2] = 1'b0;
        cycles(3);
        signal[2] = 1'b1;
        cycles(2);
        @(negedge clock);
        tests_run++;
        if (event_valid !== 1'b1 || event_key !== 2'd2 || event_type !== 2'd0) begin
            tests_failed++;
            $display("FAIL ovr_hold: got v=%b k=%0d t=%0d, want v=1 k=2 t=0",
                     event_valid, event_key, event_type);
        end
        tests_run++;
        if (overrun !== 4'b0100) begin
            tests_failed++;
            $display("FAIL ovr_flag: got %b, want 0100", overrun);
        end
        @(posedge clock);
        #1;
        event_ready = 1'b1;
        cycles(2);
        @(negedge clock);
        tests_run++;
        if (event_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_drained_valid: got %b, want 0", event_valid);
        end
        tests_run++;
        if (log_key.size() !== 2) begin
            tests_failed++;
            $display("FAIL ovr_drain_count: got %0d events, want 2", log_key.size());
        end
        if (log_key.size() == 2) begin
            tests_run++;
            if (log_key[0] !== 2 || log_type[0] !== 0 || log_key[1] !== 2 || log_type[1] !== 0) begin
                tests_failed++;
                $display("FAIL ovr_drain_seq: got (%0d,%0d)(%0d,%0d), want (2,0)(2,0)",
                         log_key[0], log_type[0], log_key[1], log_type[1]);
            end
        end
        signal = '0;
    endtask

    task automatic test_held_through_reset();
        event_ready = 1'b1;
        signal      = 4'b1000;
        do_reset();
        cycles(10);
        signal[3] = 1'b0;
        cycles(10);
        tests_run++;
        if (log_key.size() !== 0) begin
            tests_failed++;
            $display("FAIL held_reset_silent: got %0d events, want 0", log_key.size());
        end
        signal[3] = 1'b1;
        cycles(4);
        tests_run++;
        if (log_key.size() !== 1) begin
            tests_failed++;
            $display("FAIL held_reset_press_count: got %0d events, want 1", log_key.size());
        end
        if (log_key.size() == 1) begin
            tests_run++;
            if (log_key[0] !== 3 || log_type[0] !== 0) begin
                tests_failed++;
                $display("FAIL held_reset_press: got (%0d,%0d), want (3,0)", log_key[0], log_type[0]);
            end
        end
        signal = '0;
        cycles(4);
    endtask

    task automatic test_reset_mid_held();
        event_ready = 1'b0;
        do_reset();
        signal[1] = 1'b1;
        cycles(16);
        @(negedge clock);
        tests_run++;
        if (event_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_held_pre_valid: got %b, want 1", event_valid);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (event_valid !== 1'b0 || overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_held_reset: got v=%b ovr=%b, want v=0 ovr=0000", event_valid, overrun);
        end
        clear_log();
        event_ready = 1'b1;
        cycles(30);
        tests_run++;
        if (log_key.size() !== 0) begin
            tests_failed++;
            $display("FAIL mid_held_no_repeat: got %0d events, want 0", log_key.size());
        end
        signal = '0;
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_repeat();
        test_back_to_back();
        test_overrun();
        test_held_through_reset();
        test_reset_mid_held();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
